id_ex_pipe_reg: RTL
===================

// Module: id_ex_pipe_reg
// PURPOSE
//  Decode->execute pipeline register for the RV64 core. Sits directly downstream of the
//  GPR file, capturing rs1/rs2 read data plus decoded control each time decode hands off.
//  Uses a valid/ready handshake with flush support. Forwards writebacks into operands
//  that are held in the stage, so a stalled instruction never carries a stale operand.
// PARAMETERS
//  WIDTH   64  GPR/operand data width
//  CTRL_W  32  width of opaque decoded-control bundle (ALU op, imm sel, mem op, ...)
// PORTS
//  clk             in   1       clock
//  rst_n           in   1       synchronous reset, active-low
//  flush_i         in   1       kill all held entries (branch mispredict / trap)
//  in_valid_i      in   1       decode presents an instruction
//  in_ready_o      out  1       stage can accept this cycle
//  in_pc_i         in   64      instruction PC
//  in_inst_i       in   32      raw instruction
//  in_rs1_addr_i   in   5       rs1 index (forwarding compare)
//  in_rs2_addr_i   in   5       rs2 index (forwarding compare)
//  in_rs1_data_i   in   WIDTH   rs1 value from GPR file (already same-cycle bypassed)
//  in_rs2_data_i   in   WIDTH   rs2 value from GPR file
//  in_rd_addr_i    in   5       destination index
//  in_rd_wen_i     in   1       instruction writes rd
//  in_ctrl_i       in   CTRL_W  decoded control bundle
//  wb_wen_i        in   1       writeback port enable (same signals that drive the GPR file)
//  wb_addr_i       in   5       writeback index
//  wb_data_i       in   WIDTH   writeback data
//  out_valid_o     out  1       execute-side instruction valid
//  out_ready_i     in   1       execute accepts
//  out_pc_o/out_inst_o/out_rs1_addr_o/out_rs2_addr_o/out_rs1_data_o/out_rs2_data_o/
//  out_rd_addr_o/out_rd_wen_o/out_ctrl_o   out   widths as matching inputs
// BEHAVIOUR
//  - Transfer in: in_valid_i & in_ready_o. Transfer out: out_valid_o & out_ready_i.
//    Decode holds inputs stable while in_valid_i & !in_ready_o.
//  - Latency: an accepted instruction appears on out_* the next cycle. Throughput 1/cycle.
//  - Reset (rst_n=0 at posedge): all valid bits 0, all payload regs 0, so out_valid_o=0
//    and out_* = 0. in_ready_o=1 in the first cycle after reset.
//  - Payload is not cleared when valid drops. It holds its last value; the consumer
//    qualifies it with out_valid_o.
//  - Forwarding: each cycle, every valid held entry compares against the writeback port.
//    If wb_wen_i & wb_addr_i!=0 & wb_addr_i==rsN_addr, that entry's rsN_data <= wb_data_i.
//    x0 is never forwarded. Both rs1 and rs2 update if both match.
//    The capture cycle uses in_rsN_data_i as presented; the GPR file already covers the
//    same-cycle write. Forwarding into an entry that is dequeued in the same cycle has no
//    effect on that output.
//  - Flush: flush_i=1 at a posedge clears all valid bits. Any input transfer in that cycle
//    is discarded. out_valid_o=0 the next cycle. Flush overrides the handshake but not reset.
//  - Simultaneous in and out transfer on a full main register: the new entry replaces the
//    old one and valid stays 1.
// CONFIGURATION
//  ID_EX_SKID_EN defined: 2-entry stage (main + skid buffer).
//    - in_ready_o = !skid_valid, driven from a flop with no combinational path from
//      out_ready_i.
//    - An accept while main is full and out_ready_i=0 fills skid.
//    - When main drains, skid moves to main in that cycle. Order is preserved.
//    - Skid entries also receive forwarding.
//  ID_EX_SKID_EN undefined: single entry.
//    - in_ready_o = !out_valid_o | out_ready_i, which is combinational from out_ready_i.
// TESTING
//  1 Reset: hold rst_n=0 2 cycles -> out_valid_o=0, out_rs1_data_o=0, in_ready_o=1.
//  2 Stream: 4 back-to-back instrs, PC 0x80000000..0x8000000C, out_ready_i=1
//    -> outputs 1 cycle later in order, with no bubbles.
//  3 Stall + forward: hold instr rs1=5 with out_ready_i=0; drive wb_wen_i=1, wb_addr_i=5,
//    wb_data_i=0xDEADBEEF -> next cycle out_rs1_data_o=0xDEADBEEF.
//    Same with wb_addr_i=0 -> unchanged.
//  4 Flush: valid entry stalled, flush_i=1 with in_valid_i=1 the same cycle
//    -> next cycle out_valid_o=0 and the new instr is not delivered.
//  5 Backpressure (SKID_EN): out_ready_i=0 while 2 instrs are sent
//    -> in_ready_o=0 after the 2nd; release -> both delivered in order, no loss/duplication.
//  6 Backpressure (no SKID): out_ready_i=0 -> in_ready_o=0 the same cycle;
//    out_ready_i=1 -> in_ready_o=1 the same cycle.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// Decode->execute pipeline register with valid/ready handshake, flush, and writeback forwarding.
// Define ID_EX_SKID_EN for a 2-entry (main + skid) stage with a registered in_ready_o.
module id_ex_pipe_reg #(
    parameter int WIDTH  = 64,
    parameter int CTRL_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [63:0]       in_pc_i,
    input  logic [31:0]       in_inst_i,
    input  logic [4:0]        in_rs1_addr_i,
    input  logic [4:0]        in_rs2_addr_i,
    input  logic [WIDTH-1:0]  in_rs1_data_i,
    input  logic [WIDTH-1:0]  in_rs2_data_i,
    input  logic [4:0]        in_rd_addr_i,
    input  logic              in_rd_wen_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic              wb_wen_i,
    input  logic [4:0]        wb_addr_i,
    input  logic [WIDTH-1:0]  wb_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [63:0]       out_pc_o,
    output logic [31:0]       out_inst_o,
    output logic [4:0]        out_rs1_addr_o,
    output logic [4:0]        out_rs2_addr_o,
    output logic [WIDTH-1:0]  out_rs1_data_o,
    output logic [WIDTH-1:0]  out_rs2_data_o,
    output logic [4:0]        out_rd_addr_o,
    output logic              out_rd_wen_o,
    output logic [CTRL_W-1:0] out_ctrl_o
);

    typedef struct packed {
        logic [63:0]       pc;
        logic [31:0]       inst;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [WIDTH-1:0]  rs1_data;
        logic [WIDTH-1:0]  rs2_data;
        logic [4:0]        rd_addr;
        logic              rd_wen;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    // Refresh a held entry's operands from the writeback port; x0 is never forwarded.
    function automatic entry_t fwd(input entry_t e, input logic wen,
                                   input logic [4:0] addr, input logic [WIDTH-1:0] data);
        entry_t r;
        r = e;
        if (wen && (addr != 5'd0)) begin
            if (e.rs1_addr == addr) r.rs1_data = data;
            if (e.rs2_addr == addr) r.rs2_data = data;
        end
        return r;
    endfunction

    entry_t in_entry;
    entry_t main_q, main_d;
    logic   main_vld_q, main_vld_d;
    logic   in_fire, out_fire;

    always_comb begin
        in_entry          = '0;
        in_entry.pc       = in_pc_i;
        in_entry.inst     = in_inst_i;
        in_entry.rs1_addr = in_rs1_addr_i;
        in_entry.rs2_addr = in_rs2_addr_i;
        in_entry.rs1_data = in_rs1_data_i;
        in_entry.rs2_data = in_rs2_data_i;
        in_entry.rd_addr  = in_rd_addr_i;
        in_entry.rd_wen   = in_rd_wen_i;
        in_entry.ctrl     = in_ctrl_i;
    end

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = main_vld_q & out_ready_i;

`ifdef ID_EX_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_vld_q, skid_vld_d;

    // Ready depends only on a flop, breaking the out_ready_i -> in_ready_o path.
    assign in_ready_o = ~skid_vld_q;

    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_d     = main_vld_q ? fwd(main_q, wb_wen_i, wb_addr_i, wb_data_i) : main_q;
        skid_d     = skid_vld_q ? fwd(skid_q, wb_wen_i, wb_addr_i, wb_data_i) : skid_q;
        if (flush_i) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q) begin
            if (in_fire) begin
                main_vld_d = 1'b1;
                main_d     = in_entry;
            end
        end else if (out_fire) begin
            if (skid_vld_q) begin
                main_d     = fwd(skid_q, wb_wen_i, wb_addr_i, wb_data_i);
                skid_vld_d = 1'b0;
            end else if (in_fire) begin
                main_d     = in_entry;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d     = in_entry;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end
`else
    assign in_ready_o = ~main_vld_q | out_ready_i;

    always_comb begin
        main_vld_d = main_vld_q;
        main_d     = main_vld_q ? fwd(main_q, wb_wen_i, wb_addr_i, wb_data_i) : main_q;
        if (flush_i) begin
            main_vld_d = 1'b0;
        end else if (in_fire) begin
            main_vld_d = 1'b1;
            main_d     = in_entry;
        end else if (out_fire) begin
            main_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_vld_q <= 1'b0;
            main_q     <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            main_q     <= main_d;
        end
    end
`endif

    assign out_valid_o    = main_vld_q;
    assign out_pc_o       = main_q.pc;
    assign out_inst_o     = main_q.inst;
    assign out_rs1_addr_o = main_q.rs1_addr;
    assign out_rs2_addr_o = main_q.rs2_addr;
    assign out_rs1_data_o = main_q.rs1_data;
    assign out_rs2_data_o = main_q.rs2_data;
    assign out_rd_addr_o  = main_q.rd_addr;
    assign out_rd_wen_o   = main_q.rd_wen;
    assign out_ctrl_o     = main_q.ctrl;

endmodule
